// File: rtl/store_buffer_pkg.sv
// Shared definitions for the processor store buffer: default geometry and the
// entry record held in each buffer slot.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  // SB_AW/SB_DW are the defaults and also the widest address/data an entry can hold.
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [SB_DW-1:0] data;
    logic             valid;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match store-to-load forwarding search over the buffered entries.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  sb_entry_t [DEPTH-1:0]         entries,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [AW-1:0]                 lookup_adr,
  output logic                          hit,
  output logic [DW-1:0]                 data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;
  logic          unused_bits;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (entries[idx].valid &&
          entries[idx].adr[AW-1:2] == lookup_adr[AW-1:2]) begin
        hit  = 1'b1;
        data = entries[idx].data[DW-1:0];
      end
    end
  end

  assign unused_bits = ^{lookup_adr[1:0], entries};

endmodule

// File: rtl/store_buffer.sv
// Processor store buffer: FIFO of pending stores drained to data memory with a
// valid/ready handshake, plus word-granular forwarding to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  output logic          Stall,
  output logic          Empty,
  output logic          MemReqValid,
  output logic [AW-1:0] MemReqAdr,
  output logic [DW-1:0] MemReqData,
  input  logic          MemReqReady,
  output logic          FwdHit,
  output logic [DW-1:0] FwdData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]    count;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    adr_q  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];

  logic full;
  logic push;
  logic pop;

  sb_entry_t [DEPTH-1:0] entries;

  assign full        = (count == CW'(DEPTH));
  assign Stall       = full;
  assign Empty       = (count == '0);
  assign MemReqValid = !Empty;
  assign push        = MemWrite && !full;
  assign pop         = MemReqValid && MemReqReady;

  assign MemReqAdr   = adr_q[head];
  assign MemReqData  = data_q[head];

  // Control state: pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        tail        <= tail + PW'(1);
        valid[tail] <= 1'b1;
      end
      if (pop) begin
        head        <= head + PW'(1);
        valid[head] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload is only ever read through a set valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail]  <= DataAdr;
      data_q[tail] <= WriteData;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].adr   = SB_AW'(adr_q[i]);
      entries[i].data  = SB_DW'(data_q[i]);
      entries[i].valid = valid[i];
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .entries    (entries),
    .head       (head),
    .lookup_adr (DataAdr),
    .hit        (FwdHit),
    .data       (FwdData)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: memory writes are checked in order against
// a queue of expected {address,data} pairs filled as stores are issued.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0;
  logic          MemReqReady = 1'b0;
  logic          Stall;
  logic          Empty;
  logic          MemReqValid;
  logic [AW-1:0] MemReqAdr;
  logic [DW-1:0] MemReqData;
  logic          FwdHit;
  logic [DW-1:0] FwdData;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .Stall       (Stall),
    .Empty       (Empty),
    .MemReqValid (MemReqValid),
    .MemReqAdr   (MemReqAdr),
    .MemReqData  (MemReqData),
    .MemReqReady (MemReqReady),
    .FwdHit      (FwdHit),
    .FwdData     (FwdData)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && MemReqValid && MemReqReady) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL mem_write: got adr=%0h data=%0h expected no write", MemReqAdr, MemReqData);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({MemReqAdr, MemReqData} !== mon_exp) begin
          n_bad++;
          $display("FAIL mem_write: got adr=%0h data=%0h expected adr=%0h data=%0h",
                   MemReqAdr, MemReqData, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit accept);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    chk("stall_at_store", Stall, !accept);
    step();
    if (accept) exp_q.push_back({a, d});
    MemWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", Stall, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_memreqvalid", MemReqValid, 0);
    chk("rst_fwdhit", FwdHit, 0);
    chk("rst_fwddata", FwdData, 0);
    step();

    // Reset with two stores pending discards them.
    store(32'h100, 32'h11, 1);
    store(32'h104, 32'h22, 1);
    reset = 1'b1;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    MemReqReady = 1'b1;
    @(negedge clk);
    chk("midrst_empty", Empty, 1);
    chk("midrst_memreqvalid", MemReqValid, 0);
    chk("midrst_stall", Stall, 0);
    step();
    step();
    MemReqReady = 1'b0;

    // Fill to full, fifth store rejected, then drain in order.
    store(32'h00, 32'd1, 1);
    store(32'h04, 32'd2, 1);
    store(32'h08, 32'd3, 1);
    store(32'h0C, 32'd4, 1);
    store(32'h10, 32'd5, 0);
    @(negedge clk);
    chk("fill_stall", Stall, 1);
    chk("fill_head_adr", MemReqAdr, 32'h00);
    chk("fill_head_data", MemReqData, 32'd1);
    step();
    MemReqReady = 1'b1;
    repeat (4) step();
    MemReqReady = 1'b0;
    @(negedge clk);
    chk("fill_drained_empty", Empty, 1);
    step();

    // Simultaneous push and pop at count 2.
    store(32'h40, 32'h41, 1);
    store(32'h44, 32'h42, 1);
    MemReqReady = 1'b1;
    store(32'h48, 32'h43, 1);
    MemReqReady = 1'b0;
    @(negedge clk);
    chk("simul_head_adr", MemReqAdr, 32'h44);
    chk("simul_stall", Stall, 0);
    step();
    store(32'h4C, 32'h44, 1);
    store(32'h50, 32'h45, 1);
    @(negedge clk);
    chk("simul_refill_stall", Stall, 1);
    step();

    // Full with ready: pop happens, push rejected.
    MemReqReady = 1'b1;
    store(32'h54, 32'h46, 0);
    MemReqReady = 1'b0;
    @(negedge clk);
    chk("fullrdy_stall", Stall, 0);
    chk("fullrdy_head_adr", MemReqAdr, 32'h48);
    step();
    MemReqReady = 1'b1;
    repeat (3) step();
    MemReqReady = 1'b0;
    @(negedge clk);
    chk("fullrdy_empty", Empty, 1);
    step();

    // Forwarding: youngest match wins, word-granular compare.
    store(32'h20, 32'hAA, 1);
    store(32'h20, 32'hBB, 1);
    store(32'h28, 32'hCC, 1);
    DataAdr = 32'h22;
    @(negedge clk);
    chk("fwd_22_hit", FwdHit, 1);
    chk("fwd_22_data", FwdData, 32'hBB);
    step();
    DataAdr = 32'h24;
    @(negedge clk);
    chk("fwd_24_hit", FwdHit, 0);
    chk("fwd_24_data", FwdData, 0);
    step();
    DataAdr = 32'h2B;
    @(negedge clk);
    chk("fwd_2b_data", FwdData, 32'hCC);
    step();
    DataAdr = 32'h20;
    MemReqReady = 1'b1;
    @(negedge clk);
    chk("fwd_pop1_data", FwdData, 32'hBB);
    step();
    @(negedge clk);
    chk("fwd_popping_hit", FwdHit, 1);
    chk("fwd_popping_data", FwdData, 32'hBB);
    step();
    MemReqReady = 1'b0;
    @(negedge clk);
    chk("fwd_popped_hit", FwdHit, 0);
    chk("fwd_popped_data", FwdData, 0);
    step();
    DataAdr = 32'h28;
    @(negedge clk);
    chk("fwd_28_hit", FwdHit, 1);
    step();
    MemReqReady = 1'b1;
    step();
    MemReqReady = 1'b0;

    // Ten push/pop pairs wrap the pointers.
    MemReqReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      store(32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 1);
    end
    step();
    MemReqReady = 1'b0;
    @(negedge clk);
    chk("wrap_empty", Empty, 1);
    chk("wrap_pending_writes", exp_q.size(), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
